// File: rtl/debouncer.sv
// Switch debouncer: 2-flop synchronizer feeding a four-state qualification FSM.
// A new level must hold for STABLE_CYCLES synchronized samples before out follows it.
module debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_BITS      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_BITS-1:0] CntLast = CNT_BITS'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StLow     = 2'd0,
    StChkHigh = 2'd1,
    StHigh    = 2'd2,
    StChkLow  = 2'd3
  } state_e;

  logic [1:0]          sync_q;
  logic                s;
  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                out_q, out_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  // Only the second synchronizer stage may be observed by the rest of the design.
  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= StLow;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StLow: begin
        if (s) begin
          state_d = StChkHigh;
          cnt_d   = '0;
        end
      end
      StChkHigh: begin
        if (!s) begin
          state_d = StLow;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!s) begin
          state_d = StChkLow;
          cnt_d   = '0;
        end
      end
      StChkLow: begin
        if (s) begin
          state_d = StHigh;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLow;
    endcase
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == StChkHigh) || (state_q == StChkLow);

  // Structural invariants of the qualification logic.
  a_pulse_excl: assert property (@(posedge clk) disable iff (rst) !(rise_q && fall_q));
  a_cnt_bound:  assert property (@(posedge clk) disable iff (rst) cnt_q <= CntLast);

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: a vector table for reset and latency, then
// hand-written sequences for glitches, bounce, reset mid-qualification and press counting.
module tb_debouncer;

  logic clk;
  logic rst;
  logic in;
  logic out4, rise4, fall4, busy4;
  logic out1, rise1, fall1, busy1;

  int total;
  int passed;
  int rise_cnt, fall_cnt, press_cnt, viol;
  logic out_prev, rise_prev;

  debouncer #(.STABLE_CYCLES(4), .CNT_BITS(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out4),
    .rise(rise4),
    .fall(fall4),
    .busy(busy4)
  );

  debouncer #(.STABLE_CYCLES(1), .CNT_BITS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out1),
    .rise(rise1),
    .fall(fall1),
    .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream edge counter plus pulse bookkeeping, sampled mid-cycle.
  initial begin
    rise_cnt  = 0;
    fall_cnt  = 0;
    press_cnt = 0;
    viol      = 0;
    out_prev  = 1'b0;
    rise_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (rise4) rise_cnt++;
    if (fall4) fall_cnt++;
    if (out4 && !out_prev) press_cnt++;
    if (rise4 && fall4) viol++;
    if (rise4 && rise_prev) viol++;
    out_prev  = out4;
    rise_prev = rise4;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic step(input logic r, input logic i);
    rst = r;
    in  = i;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       rst;
    logic       in;
    logic [3:0] e4;  // {out, rise, fall, busy} for STABLE_CYCLES=4
    logic [3:0] e1;  // same for STABLE_CYCLES=1
  } vec_t;

  vec_t vecs [18];

  initial begin
    int r0, f0, p0;
    logic seen_a, seen_b;
    logic [10:0] press_pat;
    logic [8:0]  rel_pat;

    total  = 0;
    passed = 0;
    rst    = 1'b1;
    in     = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0000};
    vecs[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 4'b0000, 4'b0000};
    vecs[4]  = '{1'b0, 1'b1, 4'b0001, 4'b0001};
    vecs[5]  = '{1'b0, 1'b1, 4'b0001, 4'b1100};
    vecs[6]  = '{1'b0, 1'b1, 4'b0001, 4'b1000};
    vecs[7]  = '{1'b0, 1'b1, 4'b0001, 4'b1000};
    vecs[8]  = '{1'b0, 1'b1, 4'b1100, 4'b1000};
    vecs[9]  = '{1'b0, 1'b1, 4'b1000, 4'b1000};
    vecs[10] = '{1'b0, 1'b0, 4'b1000, 4'b1000};
    vecs[11] = '{1'b0, 1'b0, 4'b1000, 4'b1000};
    vecs[12] = '{1'b0, 1'b0, 4'b1001, 4'b1001};
    vecs[13] = '{1'b0, 1'b0, 4'b1001, 4'b0010};
    vecs[14] = '{1'b0, 1'b0, 4'b1001, 4'b0000};
    vecs[15] = '{1'b0, 1'b0, 4'b1001, 4'b0000};
    vecs[16] = '{1'b0, 1'b0, 4'b0010, 4'b0000};
    vecs[17] = '{1'b0, 1'b0, 4'b0000, 4'b0000};

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rst, vecs[i].in);
      check($sformatf("vec%0d_sc4", i), int'({out4, rise4, fall4, busy4}), int'(vecs[i].e4));
      check($sformatf("vec%0d_sc1", i), int'({out1, rise1, fall1, busy1}), int'(vecs[i].e1));
    end

    // High pulses of 1, 2 and 3 cycles must be rejected.
    r0 = rise_cnt;
    f0 = fall_cnt;
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int len = 1; len <= 3; len++) begin
      for (int k = 0; k < len; k++) begin
        step(1'b0, 1'b1);
        if (out4) seen_a = 1'b1;
        if (busy4) seen_b = 1'b1;
      end
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b0);
        if (out4) seen_a = 1'b1;
        if (busy4) seen_b = 1'b1;
      end
    end
    check("glitch_out", int'(seen_a), 0);
    check("glitch_busy", int'(seen_b), 1);
    check("glitch_rise", rise_cnt - r0, 0);
    check("glitch_fall", fall_cnt - f0, 0);

    // Bounce 1,0,1,0 then held: rise timed from the final 0->1.
    r0 = rise_cnt;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int j = 0; j <= 6; j++) begin
      step(1'b0, 1'b1);
      check($sformatf("bounce_rise_e%0d", j), int'(rise4), (j == 6) ? 1 : 0);
    end
    repeat (3) step(1'b0, 1'b1);
    check("bounce_out", int'(out4), 1);
    check("bounce_rise_total", rise_cnt - r0, 1);

    // Two-cycle low glitch while high.
    f0 = fall_cnt;
    seen_a = 1'b0;
    seen_b = 1'b0;
    repeat (2) begin
      step(1'b0, 1'b0);
      if (!out4) seen_a = 1'b1;
      if (busy4) seen_b = 1'b1;
    end
    repeat (8) begin
      step(1'b0, 1'b1);
      if (!out4) seen_a = 1'b1;
      if (busy4) seen_b = 1'b1;
    end
    check("lowglitch_out", int'(seen_a), 0);
    check("lowglitch_busy", int'(seen_b), 1);
    check("lowglitch_fall", fall_cnt - f0, 0);

    // Reset asserted on the third CHK_HIGH cycle.
    repeat (10) step(1'b0, 1'b0);
    check("pre_rst_out", int'(out4), 0);
    for (int j = 0; j <= 4; j++) step(1'b0, 1'b1);
    check("chk3_busy", int'(busy4), 1);
    step(1'b1, 1'b1);
    check("rst_e1_outs", int'({out4, rise4, fall4, busy4}), 0);
    step(1'b1, 1'b1);
    check("rst_e2_outs", int'({out4, rise4, fall4, busy4}), 0);
    r0 = rise_cnt;
    for (int j = 0; j <= 6; j++) begin
      step(1'b0, 1'b1);
      check($sformatf("post_rst_rise_e%0d", j), int'(rise4), (j == 6) ? 1 : 0);
    end
    check("post_rst_out", int'(out4), 1);
    repeat (3) step(1'b0, 1'b1);
    check("post_rst_rise_total", rise_cnt - r0, 1);

    // Three heavily bouncing presses into the edge counter.
    repeat (10) step(1'b0, 1'b0);
    p0 = press_cnt;
    r0 = rise_cnt;
    f0 = fall_cnt;
    press_pat = 11'b10100110101;
    rel_pat   = 9'b010110010;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 11; k++) step(1'b0, press_pat[k]);
      repeat (10) step(1'b0, 1'b1);
      for (int k = 0; k < 9; k++) step(1'b0, rel_pat[k]);
      repeat (10) step(1'b0, 1'b0);
    end
    check("press_count", press_cnt - p0, 3);
    check("press_rise", rise_cnt - r0, 3);
    check("press_fall", fall_cnt - f0, 3);
    check("press_out", int'(out4), 0);
    check("pulse_rules", viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive synchronized samples a new level SHALL hold before acceptance; legal range 1..2^CNT_BITS.
REQ-002 Parameter CNT_BITS, default 3: width of the internal stability counter.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in  input  1  raw asynchronous, possibly bouncing level, for example from a switch.
REQ-006 out  output  1  debounced, glitch-free level; drives the `in` port of the downstream edge counter.
REQ-007 rise  output  1  one-cycle pulse on each accepted 0->1 transition of out.
REQ-008 fall  output  1  one-cycle pulse on each accepted 1->0 transition of out.
REQ-009 busy  output  1  high while a candidate transition is being qualified (CHK_HIGH or CHK_LOW).

Function
REQ-010 in SHALL pass through a 2-flop synchronizer; only the second flop output, s, SHALL feed any other logic.
REQ-011 The FSM SHALL have exactly four states: LOW, CHK_HIGH, HIGH, CHK_LOW.
REQ-012 LOW, s=1: go to CHK_HIGH and clear cnt to 0. LOW, s=0: stay in LOW.
REQ-013 CHK_HIGH, s=0: return to LOW with no pulse (glitch rejected).
REQ-014 CHK_HIGH, s=1 and cnt<STABLE_CYCLES-1: increment cnt.
REQ-015 CHK_HIGH, s=1 and cnt==STABLE_CYCLES-1: go to HIGH, set out=1, assert rise for exactly one cycle.
REQ-016 HIGH, s=0: go to CHK_LOW and clear cnt. HIGH, s=1: stay in HIGH.
REQ-017 CHK_LOW mirrors CHK_HIGH with s inverted: s=1 returns to HIGH with no pulse; otherwise cnt counts up; on qualification go to LOW, set out=0, assert fall for one cycle.
REQ-018 out SHALL be 1 in HIGH and CHK_LOW, and 0 in LOW and CHK_HIGH; out SHALL be registered and SHALL change only on qualification.
REQ-019 rise and fall SHALL be registered, SHALL never be high together, and SHALL never be high on two consecutive cycles.
REQ-020 busy SHALL be 1 exactly in CHK_HIGH and CHK_LOW.
REQ-021 Latency: with in stable high from before edge E0, out and rise SHALL assert in the cycle after edge E0+STABLE_CYCLES+2; falling transitions follow the same rule for fall.
REQ-022 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-023 Any opposite sample during a CHK state SHALL restart qualification from zero on the next attempt; partial counts are discarded.
REQ-024 With STABLE_CYCLES=1, each CHK state SHALL last exactly one cycle when s holds.

Reset
REQ-025 rst=1 at a clock edge SHALL set both synchronizer flops=0, state=LOW, cnt=0, out=0, rise=0, fall=0, busy=0.
REQ-026 rst SHALL take priority over every transition, including reset during CHK_HIGH or CHK_LOW; no pulse SHALL be emitted on that edge or the following one.
REQ-027 If in=1 when rst is released, the block SHALL qualify it as a normal rising transition and emit exactly one rise pulse.

Verification (STABLE_CYCLES=4)
REQ-028 in 0->1 held indefinitely after reset -> out=1 and a single rise pulse in the cycle after edge E0+6; busy high for 4 cycles beforehand.
REQ-029 in high-pulses of 1, 2 and 3 cycles separated by 5 low cycles -> out stays 0; no rise or fall; busy toggles.
REQ-030 Bounce 1,0,1,0,1 (one cycle each) then held 1 -> exactly one rise, timed from the final 0->1 transition per REQ-021.
REQ-031 From HIGH, in 1->0 held -> a single fall pulse and out=0 after E0+6; a 2-cycle low glitch from HIGH -> out stays 1.
REQ-032 rst asserted on the third cycle of CHK_HIGH with in held 1 -> all outputs 0 during reset; after release, rise occurs a full latency later.
REQ-033 Chain out into the downstream edge counter with 3 clean presses and heavy bounce -> counter increments by exactly 3.
